// File: rtl/obi_wb_bridge_pipelined.sv
// OBI slave to Wishbone B4 pipelined master bridge: up to MAX_OUTSTANDING transfers
// in flight, in-order responses, and a cycle timeout that flushes hung transfers.
module obi_wb_bridge_pipelined #(
    parameter int unsigned       ADDR_W          = 32,
    parameter int unsigned       DATA_W          = 32,
    parameter int unsigned       MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] ADDR_MASK       = 32'h000F_FFFF,
    parameter int unsigned       TIMEOUT_CYCLES  = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                obi_req_i,
    output logic                obi_gnt_o,
    input  logic [ADDR_W-1:0]   obi_addr_i,
    input  logic                obi_we_i,
    input  logic [DATA_W/8-1:0] obi_be_i,
    input  logic [DATA_W-1:0]   obi_wdata_i,
    output logic                obi_rvalid_o,
    output logic [DATA_W-1:0]   obi_rdata_o,
    output logic                obi_err_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic                wb_we_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_stb_o,
    output logic                wb_cyc_o,
    input  logic                wb_stall_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    output logic                timeout_o
);
    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned CW   = $clog2(MAX_OUTSTANDING + 1) + 1;
    localparam int unsigned PW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned TW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] MAX_INF  = CW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FLUSH = 2'd2} state_e;

    state_e                     state_q, state_d;
    logic                       stb_q, stb_d;
    logic [ADDR_W-1:0]          adr_q, adr_d;
    logic [DATA_W-1:0]          dat_q, dat_d;
    logic                       we_q, we_d;
    logic [BE_W-1:0]            sel_q, sel_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [CW-1:0]              flush_q, flush_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic [MAX_OUTSTANDING-1:0] we_fifo_q, we_fifo_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic                       rvalid_q, rvalid_d;
    logic [DATA_W-1:0]          rdata_q, rdata_d;
    logic                       err_q, err_d;
    logic                       timeout_q, timeout_d;

    logic          accept, resp, abort, gnt, cyc;
    logic [CW-1:0] inflight;

    always_comb begin
        accept   = stb_q & ~wb_stall_i;
        resp     = (wb_ack_i | wb_err_i) & (cnt_q != '0) & (state_q == ACTIVE);
        inflight = cnt_q + CW'(stb_q);
        cyc      = (state_q == ACTIVE) & (stb_q | (cnt_q != '0));
        // A response or acceptance on the expiry cycle proves the bus is alive.
        abort    = (TIMEOUT_CYCLES != 0) && (state_q == ACTIVE) && (tmo_q == TMO_MAX)
                   && !resp && !accept;
        gnt      = rst_ni & obi_req_i & en_i & (state_q != FLUSH) & (inflight < MAX_INF)
                   & (~stb_q | ~wb_stall_i) & ~abort;

        state_d   = state_q;
        stb_d     = stb_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        we_fifo_d = we_fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rvalid_d  = 1'b0;
        rdata_d   = '0;
        err_d     = 1'b0;
        timeout_d = 1'b0;

        if (gnt) begin
            stb_d = 1'b1;
            adr_d = obi_addr_i & ADDR_MASK;
            dat_d = obi_wdata_i;
            we_d  = obi_we_i;
            sel_d = obi_be_i;
        end else if (accept) begin
            stb_d = 1'b0;
        end

        // The direction of each accepted transfer is queued so its response can be decoded.
        if (accept) begin
            we_fifo_d[wr_ptr_q] = we_q;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (resp) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
            rvalid_d = 1'b1;
            err_d    = wb_err_i;
            rdata_d  = (wb_err_i | we_fifo_q[rd_ptr_q]) ? '0 : wb_dat_i;
        end

        if (accept && !resp)      cnt_d = cnt_q + CW'(1);
        else if (resp && !accept) cnt_d = cnt_q - CW'(1);

        if (!cyc || resp || accept) tmo_d = '0;
        else                        tmo_d = tmo_q + TW'(1);

        case (state_q)
            IDLE: begin
                if (gnt) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (abort) begin
                    state_d   = FLUSH;
                    timeout_d = 1'b1;
                    stb_d     = 1'b0;
                    cnt_d     = '0;
                    flush_d   = inflight;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    tmo_d     = '0;
                end else if (cnt_d == '0 && !stb_d) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                rvalid_d = 1'b1;
                err_d    = 1'b1;
                if (flush_q <= CW'(1)) begin
                    flush_d = '0;
                    state_d = IDLE;
                end else begin
                    flush_d = flush_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            stb_q     <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            cnt_q     <= '0;
            flush_q   <= '0;
            tmo_q     <= '0;
            we_fifo_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stb_q     <= stb_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            flush_q   <= flush_d;
            tmo_q     <= tmo_d;
            we_fifo_q <= we_fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    assign obi_gnt_o    = gnt;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_we_o      = we_q;
    assign wb_sel_o     = sel_q;
    assign wb_stb_o     = stb_q;
    assign wb_cyc_o     = cyc;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_obi_wb_bridge_pipelined.sv
// Directed bench for obi_wb_bridge_pipelined with MAX_OUTSTANDING = 2, TIMEOUT_CYCLES = 16.
module tb_obi_wb_bridge_pipelined;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic        obi_req_i;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i;
    logic        obi_we_i;
    logic [3:0]  obi_be_i;
    logic [31:0] obi_wdata_i;
    logic        obi_rvalid_o;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        timeout_o;

    int n_cmp = 0;
    int n_err = 0;

    obi_wb_bridge_pipelined #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2),
        .ADDR_MASK(32'h000F_FFFF), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
        .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
        .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
        .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .timeout_o(timeout_o)
    );

    // clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Each cycle window opens 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_idle();
        obi_req_i   = 1'b0;
        obi_addr_i  = '0;
        obi_we_i    = 1'b0;
        obi_be_i    = 4'h0;
        obi_wdata_i = '0;
        wb_dat_i    = '0;
        wb_stall_i  = 1'b0;
        wb_ack_i    = 1'b0;
        wb_err_i    = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_adr,
                           input logic ack, input logic err, input logic [31:0] dat,
                           input logic [31:0] exp_rdata, input logic exp_err);
        obi_req_i  = 1'b1;
        obi_addr_i = addr;
        obi_we_i   = 1'b0;
        obi_be_i   = 4'hF;
        #1 check("rd_gnt", obi_gnt_o, 1);
        tick();
        obi_req_i = 1'b0;
        check("rd_stb", wb_stb_o, 1);
        check("rd_adr", wb_adr_o, exp_adr);
        check("rd_we", wb_we_o, 0);
        tick();
        check("rd_stb_drop", wb_stb_o, 0);
        check("rd_cyc_held", wb_cyc_o, 1);
        check("rd_no_early_rvalid", obi_rvalid_o, 0);
        wb_ack_i = ack;
        wb_err_i = err;
        wb_dat_i = dat;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        check("rd_rvalid", obi_rvalid_o, 1);
        check("rd_err", obi_err_o, exp_err);
        check("rd_rdata", obi_rdata_o, exp_rdata);
        check("rd_cyc_drop", wb_cyc_o, 0);
        tick();
        check("rd_rvalid_pulse", obi_rvalid_o, 0);
    endtask

    initial begin
        rst_ni = 1'b0;
        en_i   = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk_i);
        #1;
        obi_req_i = 1'b1;
        #1 check("rst_gnt", obi_gnt_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_rvalid", obi_rvalid_o, 0);
        obi_req_i = 1'b0;
        rst_ni = 1'b1;
        tick();
        check("post_rst_timeout", timeout_o, 0);

        // single read
        do_read(32'h4010_0024, 32'h0000_0024, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

        // three pipelined writes, ack three cycles after accept
        obi_req_i = 1'b1; obi_we_i = 1'b1; obi_be_i = 4'b0011;
        obi_addr_i = 32'h0000_0010; obi_wdata_i = 32'hA0A0_0000;
        #1 check("wr0_gnt", obi_gnt_o, 1);
        tick();
        obi_addr_i = 32'h0000_0014; obi_wdata_i = 32'hA1A1_0001;
        #1 check("wr1_gnt", obi_gnt_o, 1);
        check("wr0_sel", wb_sel_o, 4'b0011);
        check("wr0_dat", wb_dat_o, 32'hA0A0_0000);
        check("wr0_we", wb_we_o, 1);
        tick();
        obi_addr_i = 32'hF00F_0018; obi_wdata_i = 32'hA2A2_0002;
        #1 check("wr2_held_a", obi_gnt_o, 0);
        check("wr1_adr", wb_adr_o, 32'h0000_0014);
        check("wr1_dat", wb_dat_o, 32'hA1A1_0001);
        tick();
        check("wr2_held_b", obi_gnt_o, 0);
        check("wr_stb_idle", wb_stb_o, 0);
        tick();
        wb_ack_i = 1'b1;
        #1 check("wr2_held_c", obi_gnt_o, 0);
        tick();
        check("wr0_rvalid", obi_rvalid_o, 1);
        check("wr0_rdata", obi_rdata_o, 0);
        check("wr0_err", obi_err_o, 0);
        check("wr2_gnt", obi_gnt_o, 1);
        tick();
        obi_req_i = 1'b0; wb_ack_i = 1'b0;
        check("wr1_rvalid", obi_rvalid_o, 1);
        check("wr2_adr", wb_adr_o, 32'h000F_0018);
        check("wr2_dat", wb_dat_o, 32'hA2A2_0002);
        check("wr2_stb", wb_stb_o, 1);
        tick();
        check("wr_gap_rvalid", obi_rvalid_o, 0);
        check("wr2_stb_drop", wb_stb_o, 0);
        check("wr2_cyc", wb_cyc_o, 1);
        tick();
        tick();
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("wr2_rvalid", obi_rvalid_o, 1);
        check("wr_cyc_drop", wb_cyc_o, 0);
        tick();
        drive_idle();

        // stall on the first strobe
        wb_stall_i = 1'b1;
        obi_req_i = 1'b1; obi_addr_i = 32'h0000_0040;
        #1 check("st_gnt0", obi_gnt_o, 1);
        tick();
        obi_addr_i = 32'h0000_0044;
        for (int i = 0; i < 4; i++) begin
            #1 check("st_gnt_blocked", obi_gnt_o, 0);
            check("st_stb", wb_stb_o, 1);
            check("st_adr", wb_adr_o, 32'h0000_0040);
            check("st_sel", wb_sel_o, 4'h0);
            check("st_cyc", wb_cyc_o, 1);
            check("st_timeout", timeout_o, 0);
            tick();
        end
        wb_stall_i = 1'b0;
        #1 check("st_gnt1", obi_gnt_o, 1);
        tick();
        obi_req_i = 1'b0;
        check("st_adr1", wb_adr_o, 32'h0000_0044);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'h1111_1111;
        tick();
        check("st_rv0", obi_rvalid_o, 1);
        check("st_rd0", obi_rdata_o, 32'h1111_1111);
        wb_dat_i = 32'h2222_2222;
        tick();
        wb_ack_i = 1'b0;
        check("st_rv1", obi_rvalid_o, 1);
        check("st_rd1", obi_rdata_o, 32'h2222_2222);
        tick();
        check("st_cyc_drop", wb_cyc_o, 0);
        drive_idle();

        // bus errors, then a clean read
        do_read(32'h8003_1000, 32'h0003_1000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_read(32'h1234_5678, 32'h0004_5678, 1'b1, 1'b1, 32'h1234_5678, 32'h0, 1'b1);
        do_read(32'h0000_0100, 32'h0000_0100, 1'b1, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);

        // timeout with two hung reads
        obi_req_i = 1'b1; obi_addr_i = 32'h0000_0200; obi_be_i = 4'hF;
        #1 check("to_gnt0", obi_gnt_o, 1);
        tick();
        obi_addr_i = 32'h0000_0204;
        #1 check("to_gnt1", obi_gnt_o, 1);
        tick();
        obi_req_i = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) begin
            check("to_wait_pulse", timeout_o, 0);
            check("to_wait_cyc", wb_cyc_o, 1);
            tick();
        end
        check("to_pulse", timeout_o, 1);
        check("to_cyc", wb_cyc_o, 0);
        check("to_stb", wb_stb_o, 0);
        check("to_rv_none", obi_rvalid_o, 0);
        obi_req_i = 1'b1;
        #1 check("to_flush_gnt_a", obi_gnt_o, 0);
        obi_req_i = 1'b0;
        tick();
        check("to_pulse_end", timeout_o, 0);
        check("to_rv0", obi_rvalid_o, 1);
        check("to_err0", obi_err_o, 1);
        check("to_rd0", obi_rdata_o, 0);
        wb_ack_i = 1'b1; wb_dat_i = 32'h5555_5555;
        obi_req_i = 1'b1;
        #1 check("to_flush_gnt_b", obi_gnt_o, 0);
        obi_req_i = 1'b0;
        tick();
        check("to_rv1", obi_rvalid_o, 1);
        check("to_err1", obi_err_o, 1);
        check("to_rd1", obi_rdata_o, 0);
        tick();
        wb_ack_i = 1'b0;
        check("to_late_ack", obi_rvalid_o, 0);
        tick();
        check("to_late_ack2", obi_rvalid_o, 0);
        check("to_idle_cyc", wb_cyc_o, 0);
        do_read(32'h0000_0300, 32'h0000_0300, 1'b1, 1'b0, 32'h7777_0001, 32'h7777_0001, 1'b0);
        drive_idle();

        // en_i low blocks grants, in-flight read still completes
        obi_req_i = 1'b1; obi_addr_i = 32'h0000_0400; obi_be_i = 4'hF;
        #1 check("en_gnt0", obi_gnt_o, 1);
        tick();
        obi_req_i = 1'b0;
        tick();
        en_i = 1'b0; obi_req_i = 1'b1; obi_addr_i = 32'h0000_0404;
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
        #1 check("en_blocked_a", obi_gnt_o, 0);
        tick();
        wb_ack_i = 1'b0;
        check("en_rvalid", obi_rvalid_o, 1);
        check("en_rdata", obi_rdata_o, 32'hCAFE_F00D);
        check("en_blocked_b", obi_gnt_o, 0);
        tick();
        en_i = 1'b1;
        #1 check("en_restored", obi_gnt_o, 1);
        obi_req_i = 1'b0;
        tick();
        drive_idle();

        // reset with two transfers outstanding
        obi_req_i = 1'b1; obi_addr_i = 32'h0000_0500; obi_be_i = 4'hF;
        #1 check("rs_gnt0", obi_gnt_o, 1);
        tick();
        obi_addr_i = 32'h0000_0504;
        #1 check("rs_gnt1", obi_gnt_o, 1);
        tick();
        tick();
        check("rs_cyc_before", wb_cyc_o, 1);
        rst_ni = 1'b0;
        #1 check("rs_stb", wb_stb_o, 0);
        check("rs_cyc", wb_cyc_o, 0);
        check("rs_gnt", obi_gnt_o, 0);
        check("rs_adr", wb_adr_o, 0);
        check("rs_rvalid", obi_rvalid_o, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        obi_req_i = 1'b0;
        wb_ack_i = 1'b1; wb_dat_i = 32'h9999_9999;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rs_no_rvalid", obi_rvalid_o, 0);
            check("rs_no_cyc", wb_cyc_o, 0);
        end
        drive_idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/obi_wb_bridge_pipelined.md
Name: obi_wb_bridge_pipelined

Overview:
- Single-clock OBI-slave to Wishbone B4 pipelined-master bridge. Successor to the two-clock single-transfer bridge.
- Accepts up to MAX_OUTSTANDING OBI requests in flight and honours wb_stall_i.
- Returns responses to the OBI master in order. Maps wb_err_i to obi_err_o.
- Aborts hung transfers with a cycle timeout. Sits between the core data port and the peripheral Wishbone interconnect.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transfers (1..8).
- ADDR_MASK, 32'h000F_FFFF, AND-mask applied to obi_addr_i to form wb_adr_o.
- TIMEOUT_CYCLES, 255, response timeout in cycles (0 disables timeout).

Ports:
- clk_i  in  1  bridge clock
- rst_ni  in  1  asynchronous reset, active low
- en_i  in  1  enable for new grants
- obi_req_i  in  1  OBI request
- obi_gnt_o  out  1  OBI grant (combinational)
- obi_addr_i  in  ADDR_W  OBI address
- obi_we_i  in  1  1 = write, 0 = read
- obi_be_i  in  DATA_W/8  byte enables
- obi_wdata_i  in  DATA_W  write data
- obi_rvalid_o  out  1  response valid, one-cycle pulse per transfer
- obi_rdata_o  out  DATA_W  read data
- obi_err_o  out  1  response error, qualified by obi_rvalid_o
- wb_adr_o  out  ADDR_W  Wishbone address
- wb_dat_o  out  DATA_W  Wishbone write data
- wb_dat_i  in  DATA_W  Wishbone read data
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  DATA_W/8  Wishbone byte select
- wb_stb_o  out  1  Wishbone strobe
- wb_cyc_o  out  1  Wishbone cycle
- wb_stall_i  in  1  slave stall
- wb_ack_i  in  1  slave acknowledge
- wb_err_i  in  1  slave error
- timeout_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Clocking/reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni. During reset all outputs are 0, counters are cleared, state is IDLE.
- Reset mid-transfer drops all in-flight transfers with no OBI response.
- Definitions:
  - accept = wb_stb_o & ~wb_stall_i.
  - resp = (wb_ack_i | wb_err_i) & (cnt_q != 0). cnt_q counts accepted, unanswered transfers.
  - inflight = cnt_q + wb_stb_o.
- State machine:
  - IDLE: cyc 0. Moves to ACTIVE on a grant.
  - ACTIVE: moves to IDLE when inflight becomes 0. Moves to FLUSH on timeout.
  - FLUSH: moves to IDLE when the flush count reaches 0.
- Grant: obi_gnt_o = obi_req_i & en_i & state != FLUSH & inflight < MAX_OUTSTANDING & (~wb_stb_o | ~wb_stall_i).
- Request issue: on req&gnt at edge T, from T+1 the outputs are:
  - wb_stb_o = 1.
  - wb_adr_o = obi_addr_i & ADDR_MASK.
  - wb_dat_o, wb_we_o and wb_sel_o take obi_wdata_i, obi_we_i and obi_be_i.
- Stall and back-to-back:
  - While stb_o is high and stall_i is high, all request outputs hold unchanged.
  - After accept, stb_o drops unless a new grant occurs the same cycle.
  - A new grant in the accept cycle gives back-to-back strobes.
- wb_cyc_o = wb_stb_o | (cnt_q != 0) in ACTIVE; 0 in IDLE and FLUSH. It drops the cycle after the final response.
- Outstanding counter: cnt_q += accept, -= resp. Simultaneous accept and resp leaves it unchanged.
- Response path (one cycle after resp):
  - obi_rvalid_o = 1.
  - obi_rdata_o = wb_dat_i for reads, 0 for writes and for errors.
  - obi_err_o = wb_err_i.
  - If ack and err are both high, the response is an error.
  - Responses are strictly in order. Best-case latency is gnt edge T → stb T+1 → ack T+2 → rvalid T+3.
- Spurious responses: ack/err with cnt_q = 0 is ignored.
- Timeout counter:
  - Clears on resp, on accept, or when cyc is low.
  - Increments while cyc_o is high with no resp and no accept.
  - When it equals TIMEOUT_CYCLES (non-zero) it triggers abort.
- Abort sequence:
  - Next cycle: timeout_o pulses, stb_o and cyc_o drop, and the bridge enters FLUSH with flush count = inflight.
  - FLUSH issues one obi_rvalid_o with obi_err_o = 1 and rdata 0 per cycle until the count is 0, then returns to IDLE.
  - wb_ack_i and wb_err_i are ignored in FLUSH.
- en_i low: blocks new grants only; in-flight transfers complete normally.

Test Plan:
- Single read: req addr 0x4010_0024, slave acks with 0xDEADBEEF one cycle after accept → wb_adr_o = 0x0000_0024 with stb for 1 cycle; obi_rvalid_o 3 cycles after grant with rdata 0xDEADBEEF, err 0.
- Pipelined writes, MAX_OUTSTANDING = 2: three back-to-back writes, be 4'b0011, no stall, ack latency 3 → first two granted consecutively, third held until first ack; three rvalids in order; wb_sel_o = 0011.
- Stall: wb_stall_i high 4 cycles on the first strobe → address/data/sel stable, no further gnt beyond inflight limit, cyc held, timeout counter not expired.
- Bus error: read answered with wb_err_i → obi_rvalid_o with obi_err_o = 1, rdata 0; next transfer proceeds normally. Also ack and err asserted together → error response.
- Timeout: TIMEOUT_CYCLES = 16, two accepted reads never acked → timeout_o pulse, cyc/stb low, two consecutive error rvalids, late ack ignored, new request granted afterwards.
- Reset and enable: assert rst_ni low with two transfers outstanding → all outputs 0 immediately, no rvalid after release. en_i low with req high → gnt stays 0 while in-flight ack still produces rvalid.
